imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/imem_loader_byte_packer.sv | 37 +++
 rtl/imem_loader.sv | 107 ++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared constants and FSM encoding for the instruction-memory loader.
// The header length equals one instruction word, so one packer serves both header and data.
package imem_loader_pkg;

  localparam int PC_WIDTH   = 32;
  localparam int INST_WIDTH = 32;
  localparam int MEM_WIDTH  = 1024;
  localparam int LEN_BYTES  = 4;
  localparam int CNT_WIDTH  = $clog2(LEN_BYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LEN  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word assembler. word/word_valid are combinational so the
// caller sees the completed word in the same cycle its last byte is accepted.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_data,
  output logic [8*LEN_BYTES-1:0] word,
  output logic                   word_valid
);

  logic [8*(LEN_BYTES-1)-1:0] acc;
  logic [CNT_WIDTH-1:0]       count;

  // Newest byte lands on top; after LEN_BYTES shifts the first byte sits in bits 7:0.
  assign word       = {byte_data, acc};
  assign word_valid = byte_valid && (count == CNT_WIDTH'(LEN_BYTES - 1));

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc   <= '0;
      count <= '0;
    end else if (clear) begin
      acc   <= '0;
      count <= '0;
    end else if (byte_valid) begin
      acc   <= word[8*LEN_BYTES-1:8];
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed byte image from a host into IMEM while holding the core.
// Header: 4-byte little-endian word count N, followed by N little-endian 32-bit words.
module imem_loader #(
  parameter int PC_WIDTH   = imem_loader_pkg::PC_WIDTH,
  parameter int INST_WIDTH = imem_loader_pkg::INST_WIDTH,
  parameter int MEM_WIDTH  = imem_loader_pkg::MEM_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load_start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  imem_wr_en,
  output logic [PC_WIDTH-1:0]   imem_wr_addr,
  output logic [INST_WIDTH-1:0] imem_wr_data,
  output logic                  core_hold,
  output logic                  load_done,
  output logic                  load_err
);

  import imem_loader_pkg::*;

  state_e                state;
  logic [PC_WIDTH-1:0]   word_idx;
  logic [PC_WIDTH-1:0]   last_idx;
  logic [INST_WIDTH-1:0] word;
  logic                  word_valid;
  logic                  accept;
  logic                  clear;

  assign accept = byte_valid && byte_ready;
  assign clear  = (state == IDLE) && load_start;

  byte_packer u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .byte_valid (accept),
    .byte_data  (byte_data),
    .word       (word),
    .word_valid (word_valid)
  );

  // All outputs are registered; byte_ready/core_hold are set on the transition
  // into the state that owns them so they line up with the state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      byte_ready   <= 1'b0;
      imem_wr_en   <= 1'b0;
      imem_wr_addr <= '0;
      imem_wr_data <= '0;
      core_hold    <= 1'b0;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      word_idx     <= '0;
      last_idx     <= '0;
    end else begin
      imem_wr_en <= 1'b0;
      load_done  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (load_start) begin
            state      <= LEN;
            byte_ready <= 1'b1;
            core_hold  <= 1'b1;
            load_err   <= 1'b0;
            word_idx   <= '0;
          end
        end
        LEN: begin
          if (word_valid) begin
            // Empty and oversize images both finish immediately; only oversize is an error.
            if (word == '0 || word > INST_WIDTH'(MEM_WIDTH)) begin
              state      <= DONE;
              byte_ready <= 1'b0;
              load_done  <= 1'b1;
              load_err   <= (word != '0);
            end else begin
              state    <= DATA;
              last_idx <= PC_WIDTH'(word - 1'b1);
            end
          end
        end
        DATA: begin
          if (word_valid) begin
            imem_wr_en   <= 1'b1;
            imem_wr_addr <= word_idx << 2;
            imem_wr_data <= word;
            word_idx     <= word_idx + 1'b1;
            if (word_idx == last_idx) begin
              state      <= DONE;
              byte_ready <= 1'b0;
              load_done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          core_hold <= 1'b0;
        end
      endcase
    end
  end

endmodule
